bitwise16_seq_unit: RTL
=======================

// Module: bitwise16_seq_unit
// PURPOSE
//  Parametrised, sequential successor to the fixed 16-bit AND gate block.
//  Multi-op bitwise logic unit: accepts two WIDTH-bit operands plus an op code.
//  Processes LANE bits per clock and returns the WIDTH-bit result.
//  Valid/ready handshakes on both sides; feeds ALU/datapath blocks in the design.
// PARAMETERS
//  WIDTH  16  operand/result width in bits
//  LANE   4   bits processed per cycle; must divide WIDTH (elaboration fails otherwise)
//  BEATS = WIDTH/LANE is derived (localparam), not a parameter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      unit can accept (high only in IDLE)
//  op         in   3      operation select, sampled on accept
//  a          in   WIDTH  operand A, sampled on accept
//  b          in   WIDTH  operand B, sampled on accept
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  out        out  WIDTH  result, valid while out_valid=1
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, beat count=0, out=0, out_valid=0, busy=0.
//   in_ready=1 once rst_n=1. Any in-flight transaction is discarded.
//  Op codes, applied per bit i:
//   000 a&b, 001 a|b, 010 a^b, 011 ~(a&b), 100 ~(a|b), 101 ~(a^b), 110 ~a, 111 a&~b.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1.
//    On an in_valid&in_ready edge E0: latch a, b and op; out<=0; cnt<=0; go to RUN.
//   RUN: at each edge, write out[cnt*LANE +: LANE] = f(op, a_lane, b_lane); cnt<=cnt+1.
//    When cnt==BEATS-1, write the last lane and go to DONE.
//   DONE: out_valid=1; out stable. On an out_valid&out_ready edge: out_valid<=0, go to IDLE.
//  Latency: out_valid rises after edge E0+BEATS. With defaults, 4 cycles.
//   Earliest next accept is at edge E0+BEATS+2.
//  in_valid while in RUN or DONE: ignored, no capture. Changes to a, b or op after E0 have no effect.
//  out_ready while out_valid=0: ignored.
//  Backpressure: DONE holds out and out_valid indefinitely until out_ready.
//  BEATS==1 (LANE==WIDTH): RUN lasts exactly 1 cycle; the same rules apply.
//  cnt is $clog2(BEATS)+1 bits wide and never wraps past BEATS-1.
//  Pure bitwise operation: no carries, no sign, widths never extend.
// TESTING
//  1 Reset: rst_n=0 -> out=0, out_valid=0, busy=0. Release -> in_ready=1 next cycle.
//  2 AND: a=16'h00FF, b=16'hFFFF, op=000 -> out=16'h00FF; out_valid exactly 4 edges after accept.
//  3 Op sweep: a=16'hF0F0, b=16'hCCCC, op 000..111 ->
//     C0C0, FCFC, 3C3C, 3F3F, 0303, C3C3, 0F0F, 3030.
//  4 Backpressure: out_ready=0 for 10 cycles -> out_valid stays 1, out stable, in_ready=0.
//     New in_valid is not captured. Then out_ready=1 -> IDLE on the next edge.
//  5 Mid-op reset: rst_n low during the 2nd RUN beat -> immediate out=0, out_valid=0.
//     After release, a=16'hAAAA, b=16'h5555, op=001 -> out=16'hFFFF.
//  6 Params: WIDTH=32, LANE=8, a=32'h12345678, b=32'hFFFF0000, op=000 -> 32'h12340000 after 4 beats.
//     WIDTH=16, LANE=16 -> latency 1.

Source files
------------

// File: rtl/bitwise16_seq_unit.sv
// Sequential multi-op bitwise unit: applies one of eight bitwise ops to two WIDTH-bit
// operands, LANE bits per clock, behind valid/ready handshakes on both sides.
module bitwise16_seq_unit #(
   parameter int WIDTH = 16,
   parameter int LANE  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy
);

   localparam int BEATS = WIDTH / LANE;
   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   generate
      if ((WIDTH % LANE) != 0) begin : g_lane_check
         $error("bitwise16_seq_unit: LANE must divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] out_q;
   logic [LANE-1:0]  lane_a;
   logic [LANE-1:0]  lane_b;
   logic [LANE-1:0]  lane_res;
   logic             accept;
   logic             last_beat;
   int               lane_base;

   function automatic logic [LANE-1:0] lane_op(input logic [2:0]      sel,
                                               input logic [LANE-1:0] x,
                                               input logic [LANE-1:0] y);
      logic [LANE-1:0] r;
      case (sel)
         3'b000:  r = x & y;
         3'b001:  r = x | y;
         3'b010:  r = x ^ y;
         3'b011:  r = ~(x & y);
         3'b100:  r = ~(x | y);
         3'b101:  r = ~(x ^ y);
         3'b110:  r = ~x;
         default: r = x & ~y;
      endcase
      return r;
   endfunction

   assign accept    = in_valid && (state == IDLE);
   assign last_beat = (cnt == LAST);
   assign lane_base = int'(cnt) * LANE;
   assign lane_a    = a_q[lane_base +: LANE];
   assign lane_b    = b_q[lane_base +: LANE];
   assign lane_res  = lane_op(op_q, lane_a, lane_b);
   assign out       = out_q;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_beat) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         out_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt   <= '0;
                  out_q <= '0;
               end
            end
            RUN: begin
               out_q[lane_base +: LANE] <= lane_res;
               // counter parks on the last beat so it never leaves 0..BEATS-1
               if (!last_beat) cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // operand capture is data only: gated by accept, no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= a;
         b_q  <= b;
         op_q <= op;
      end
   end

endmodule
